// File: rtl/micros_alarm_scheduler.sv
// Multi-channel alarm scheduler on top of the free-running microsecond counter.
// One wrap-safe comparator is time-shared across channels by a round-robin scan pointer.
module micros_alarm_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       micros,
  input  logic              arm_valid,
  input  logic [CH_W-1:0]   arm_ch,
  input  logic [31:0]       arm_delay,
  input  logic [31:0]       arm_period,
  input  logic              disarm_valid,
  input  logic [CH_W-1:0]   disarm_ch,
  input  logic              ack_valid,
  input  logic [NUM_CH-1:0] ack_mask,
  output logic [NUM_CH-1:0] armed,
  output logic [NUM_CH-1:0] pending,
  output logic              irq,
  output logic              fire_valid,
  output logic [CH_W-1:0]   fire_ch
);

  localparam logic [31:0] MAX_REL = 32'h7FFF_FFFF;

  logic [31:0]       deadline [NUM_CH];
  logic [31:0]       period   [NUM_CH];
  logic [CH_W-1:0]   ptr;
  logic              ptr_last;

  logic [31:0]       eff_delay;
  logic [31:0]       eff_period;
  logic [NUM_CH-1:0] arm_sel;
  logic [NUM_CH-1:0] disarm_sel;
  logic [NUM_CH-1:0] fire_sel;
  logic [31:0]       scan_deadline;
  logic              scan_armed;
  logic [31:0]       scan_diff;
  logic              scan_hit;

  // Relative times are kept below 2^31 so the sign-bit comparison stays unambiguous.
  always_comb begin
    eff_delay  = arm_delay[31]  ? MAX_REL : arm_delay;
    eff_period = arm_period[31] ? MAX_REL : arm_period;
  end

  // Channel indices that do not exist never match a decode slot, so such commands fall away.
  always_comb begin
    arm_sel       = '0;
    disarm_sel    = '0;
    fire_sel      = '0;
    scan_deadline = '0;
    scan_armed    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arm_valid && (arm_ch == CH_W'(i)))
        arm_sel[i] = 1'b1;
      if (disarm_valid && (disarm_ch == CH_W'(i)))
        disarm_sel[i] = 1'b1;
      if (ptr == CH_W'(i)) begin
        scan_deadline = deadline[i];
        scan_armed    = armed[i];
      end
    end
    scan_diff = micros - scan_deadline;
    scan_hit  = scan_armed && !scan_diff[31];
    for (int i = 0; i < NUM_CH; i++)
      fire_sel[i] = scan_hit && (ptr == CH_W'(i)) && !arm_sel[i] && !disarm_sel[i];
  end

  assign ptr_last = (ptr == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      armed      <= '0;
      pending    <= '0;
      irq        <= 1'b0;
      fire_valid <= 1'b0;
      fire_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        deadline[i] <= '0;
        period[i]   <= '0;
      end
    end else begin
      ptr        <= ptr_last ? '0 : ptr + CH_W'(1);
      fire_valid <= |fire_sel;
      if (|fire_sel)
        fire_ch <= ptr;
      irq <= |pending;
      for (int i = 0; i < NUM_CH; i++) begin
        // Arm beats disarm and a same-cycle hit; disarm beats a hit.
        if (arm_sel[i]) begin
          deadline[i] <= micros + eff_delay;
          period[i]   <= eff_period;
          armed[i]    <= 1'b1;
        end else if (disarm_sel[i]) begin
          armed[i] <= 1'b0;
        end else if (fire_sel[i]) begin
          if (period[i] != 32'd0)
            deadline[i] <= deadline[i] + period[i];
          else
            armed[i] <= 1'b0;
        end
        pending[i] <= fire_sel[i] | (pending[i] & ~(ack_valid & ack_mask[i]));
      end
    end
  end

endmodule

// File: tb/tb_micros_alarm_scheduler.sv
// Self-checking bench for micros_alarm_scheduler: table of single-channel arm cases
// followed by hand-written collision, concurrency and reset sequences.
module tb_micros_alarm_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       micros = '0;
  logic              arm_valid = 1'b0;
  logic [CH_W-1:0]   arm_ch = '0;
  logic [31:0]       arm_delay = '0;
  logic [31:0]       arm_period = '0;
  logic              disarm_valid = 1'b0;
  logic [CH_W-1:0]   disarm_ch = '0;
  logic              ack_valid = 1'b0;
  logic [NUM_CH-1:0] ack_mask = '0;
  logic [NUM_CH-1:0] armed;
  logic [NUM_CH-1:0] pending;
  logic              irq;
  logic              fire_valid;
  logic [CH_W-1:0]   fire_ch;

  micros_alarm_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .micros(micros),
    .arm_valid(arm_valid), .arm_ch(arm_ch), .arm_delay(arm_delay), .arm_period(arm_period),
    .disarm_valid(disarm_valid), .disarm_ch(disarm_ch),
    .ack_valid(ack_valid), .ack_mask(ack_mask),
    .armed(armed), .pending(pending), .irq(irq),
    .fire_valid(fire_valid), .fire_ch(fire_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [31:0]     start;
    logic [31:0]     delay;
    logic [31:0]     per;
    logic [31:0]     exp_dl;
    logic [31:0]     exp_per;
    int              run_us;
    int              exp_fires;
    logic [31:0]     exp_first;
    logic [31:0]     exp_final_dl;
    logic [3:0]      exp_pending;
    logic [3:0]      exp_armed;
  } vec_t;

  typedef struct {
    logic [31:0]     at;
    logic [CH_W-1:0] ch;
    int              cyc;
  } fire_t;

  vec_t        vecs[5];
  fire_t       fq[$];
  logic [31:0] prev_micros = '0;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  // Every fire pulse is logged with the micros value of the scan-hit cycle before it.
  always @(negedge clk) begin
    if (fire_valid)
      fq.push_back('{at: prev_micros, ch: fire_ch, cyc: cyc});
    prev_micros <= micros;
    cyc         <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [31:0] dly, input logic [31:0] per);
    arm_valid  = 1'b1;
    arm_ch     = ch;
    arm_delay  = dly;
    arm_period = per;
    tick();
    arm_valid  = 1'b0;
  endtask

  task automatic doReset();
    reset        = 1'b0;
    arm_valid    = 1'b0;
    disarm_valid = 1'b0;
    ack_valid    = 1'b0;
    ack_mask     = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic runMicros(input int n);
    repeat (n) begin
      repeat (8) tick();
      micros = micros + 32'd1;
    end
  endtask

  task automatic waitPtr(input logic [CH_W-1:0] p);
    int n = 0;
    while (dut.ptr != p && n < 16) begin
      tick();
      n++;
    end
    checkOutput("ptr_sync", 32'(dut.ptr), 32'(p));
  endtask

  function automatic int firesSince(input int base);
    return fq.size() - base;
  endfunction

  function automatic logic [3:0] maskSince(input int base);
    logic [3:0] m = '0;
    for (int i = base; i < fq.size(); i++)
      m[fq[i].ch] = 1'b1;
    return m;
  endfunction

  initial begin
    int base;
    logic [3:0] exp_mask;

    vecs[0] = '{ch: 2'd1, start: 32'd1000, delay: 32'd5, per: 32'd0, exp_dl: 32'd1005, exp_per: 32'd0,
                run_us: 10, exp_fires: 1, exp_first: 32'd1005, exp_final_dl: 32'd1005,
                exp_pending: 4'b0010, exp_armed: 4'b0000};
    vecs[1] = '{ch: 2'd0, start: 32'hFFFF_FFFE, delay: 32'd4, per: 32'd0, exp_dl: 32'd2, exp_per: 32'd0,
                run_us: 8, exp_fires: 1, exp_first: 32'd2, exp_final_dl: 32'd2,
                exp_pending: 4'b0001, exp_armed: 4'b0000};
    vecs[2] = '{ch: 2'd3, start: 32'd50, delay: 32'd0, per: 32'd0, exp_dl: 32'd50, exp_per: 32'd0,
                run_us: 3, exp_fires: 1, exp_first: 32'd50, exp_final_dl: 32'd50,
                exp_pending: 4'b1000, exp_armed: 4'b0000};
    vecs[3] = '{ch: 2'd2, start: 32'd7, delay: 32'h8000_0000, per: 32'h9000_0000,
                exp_dl: 32'h8000_0006, exp_per: 32'h7FFF_FFFF,
                run_us: 5, exp_fires: 0, exp_first: 32'd0, exp_final_dl: 32'h8000_0006,
                exp_pending: 4'b0000, exp_armed: 4'b0100};
    vecs[4] = '{ch: 2'd2, start: 32'd0, delay: 32'd10, per: 32'd10, exp_dl: 32'd10, exp_per: 32'd10,
                run_us: 35, exp_fires: 3, exp_first: 32'd10, exp_final_dl: 32'd40,
                exp_pending: 4'b0100, exp_armed: 4'b0100};

    // Reset values
    repeat (2) tick();
    checkOutput("rst_armed", 32'(armed), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_fire_valid", 32'(fire_valid), 32'd0);
    checkOutput("rst_fire_ch", 32'(fire_ch), 32'd0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      doReset();
      micros = vecs[v].start;
      base = fq.size();
      applyStimulus(vecs[v].ch, vecs[v].delay, vecs[v].per);
      checkOutput($sformatf("v%0d_deadline", v), dut.deadline[vecs[v].ch], vecs[v].exp_dl);
      checkOutput($sformatf("v%0d_period", v), dut.period[vecs[v].ch], vecs[v].exp_per);
      runMicros(vecs[v].run_us);
      checkOutput($sformatf("v%0d_fires", v), 32'(firesSince(base)), 32'(vecs[v].exp_fires));
      if (vecs[v].exp_fires > 0 && firesSince(base) > 0)
        checkOutput($sformatf("v%0d_first_at", v), fq[base].at, vecs[v].exp_first);
      exp_mask = (vecs[v].exp_fires > 0) ? (4'b0001 << vecs[v].ch) : 4'b0000;
      checkOutput($sformatf("v%0d_fire_ch", v), 32'(maskSince(base)), 32'(exp_mask));
      checkOutput($sformatf("v%0d_pending", v), 32'(pending), 32'(vecs[v].exp_pending));
      checkOutput($sformatf("v%0d_irq", v), 32'(irq), 32'(|vecs[v].exp_pending));
      checkOutput($sformatf("v%0d_armed", v), 32'(armed), 32'(vecs[v].exp_armed));
      checkOutput($sformatf("v%0d_final_dl", v), dut.deadline[vecs[v].ch], vecs[v].exp_final_dl);
    end

    // Disarm the periodic channel left running by the last vector, then acknowledge it
    disarm_valid = 1'b1;
    disarm_ch    = 2'd2;
    tick();
    disarm_valid = 1'b0;
    base = fq.size();
    runMicros(50);
    checkOutput("disarm_no_fire", 32'(firesSince(base)), 32'd0);
    checkOutput("disarm_armed", 32'(armed), 32'd0);
    ack_valid = 1'b1;
    ack_mask  = 4'b0100;
    tick();
    ack_valid = 1'b0;
    checkOutput("ack_pending", 32'(pending), 32'd0);
    checkOutput("ack_irq_lag", 32'(irq), 32'd1);
    tick();
    checkOutput("ack_irq", 32'(irq), 32'd0);

    // Re-arm lands in the very cycle the stale deadline is scanned
    doReset();
    micros = 32'd100;
    base = fq.size();
    waitPtr(2'd2);
    applyStimulus(2'd3, 32'd0, 32'd0);
    applyStimulus(2'd3, 32'd50, 32'd0);
    checkOutput("coll_arm_fire_valid", 32'(fire_valid), 32'd0);
    runMicros(2);
    checkOutput("coll_arm_fires", 32'(firesSince(base)), 32'd0);
    checkOutput("coll_arm_deadline", dut.deadline[3], 32'd152 - 32'd2);
    checkOutput("coll_arm_armed", 32'(armed), 32'b1000);
    micros = 32'd150;
    runMicros(1);
    checkOutput("coll_arm_later_fire", 32'(firesSince(base)), 32'd1);

    // Disarm in the hit cycle suppresses the fire
    doReset();
    micros = 32'd120;
    base = fq.size();
    waitPtr(2'd0);
    applyStimulus(2'd1, 32'd0, 32'd0);
    disarm_valid = 1'b1;
    disarm_ch    = 2'd1;
    tick();
    disarm_valid = 1'b0;
    checkOutput("coll_disarm_fire_valid", 32'(fire_valid), 32'd0);
    repeat (8) tick();
    checkOutput("coll_disarm_fires", 32'(firesSince(base)), 32'd0);
    checkOutput("coll_disarm_pending", 32'(pending), 32'd0);
    checkOutput("coll_disarm_armed", 32'(armed), 32'd0);

    // Ack of the bit that fires in the same cycle loses
    doReset();
    micros = 32'd200;
    waitPtr(2'd3);
    applyStimulus(2'd0, 32'd0, 32'd0);
    ack_valid = 1'b1;
    ack_mask  = 4'b0001;
    tick();
    ack_valid = 1'b0;
    checkOutput("coll_ack_fire_valid", 32'(fire_valid), 32'd1);
    checkOutput("coll_ack_fire_ch", 32'(fire_ch), 32'd0);
    checkOutput("coll_ack_pending", 32'(pending), 32'b0001);
    tick();
    checkOutput("coll_ack_fire_pulse", 32'(fire_valid), 32'd0);
    checkOutput("coll_ack_irq", 32'(irq), 32'd1);

    // Arm and disarm on the same channel: arm wins
    doReset();
    micros = 32'd400;
    arm_valid    = 1'b1;
    arm_ch       = 2'd2;
    arm_delay    = 32'd10;
    arm_period   = 32'd0;
    disarm_valid = 1'b1;
    disarm_ch    = 2'd2;
    tick();
    arm_valid    = 1'b0;
    disarm_valid = 1'b0;
    checkOutput("arm_vs_disarm_armed", 32'(armed), 32'b0100);
    checkOutput("arm_vs_disarm_deadline", dut.deadline[2], 32'd410);

    // All channels expiring on the same micros value
    doReset();
    micros = 32'd300;
    for (int c = 0; c < NUM_CH; c++)
      applyStimulus(CH_W'(c), 32'd3, 32'd0);
    base = fq.size();
    runMicros(6);
    checkOutput("conc_fires", 32'(firesSince(base)), 32'd4);
    checkOutput("conc_mask", 32'(maskSince(base)), 32'b1111);
    if (firesSince(base) > 0) begin
      checkOutput("conc_at", fq[base].at, 32'd303);
      checkOutput("conc_spread_ok", 32'((fq[fq.size()-1].cyc - fq[base].cyc) <= 3), 32'd1);
    end
    checkOutput("conc_pending", 32'(pending), 32'b1111);
    checkOutput("conc_irq", 32'(irq), 32'd1);

    // Asynchronous reset in the middle of a cycle
    applyStimulus(2'd0, 32'd100, 32'd10);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_armed", 32'(armed), 32'd0);
    checkOutput("mid_rst_pending", 32'(pending), 32'd0);
    checkOutput("mid_rst_irq", 32'(irq), 32'd0);
    checkOutput("mid_rst_fire_valid", 32'(fire_valid), 32'd0);
    checkOutput("mid_rst_fire_ch", 32'(fire_ch), 32'd0);
    tick();
    reset = 1'b1;
    base = fq.size();
    runMicros(20);
    checkOutput("post_rst_fires", 32'(firesSince(base)), 32'd0);
    checkOutput("post_rst_armed", 32'(armed), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/micros_alarm_scheduler.md
# micros_alarm_scheduler

Multi-channel alarm scheduler layered on the free-running 32-bit microsecond counter. The CPU arms up to NUM_CH independent one-shot or periodic alarms, each with a relative delay in microseconds. The block shares a single wrap-safe comparator across all channels by scanning them round-robin, latches expiries into pending flags, and raises one level interrupt toward the interrupt controller.

## Interface
- NUM_CH, 4: number of alarm channels; legal range 1..64
- CH_W, 2: channel index width, equal to max(1, clog2(NUM_CH))
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low; all state is cleared while low
- micros  input  32  current microsecond count from the microsecond counter
- arm_valid  input  1  single-cycle arm command
- arm_ch  input  CH_W  channel to arm
- arm_delay  input  32  delay in µs, relative to micros sampled in the arm cycle
- arm_period  input  32  reload period in µs; 0 selects one-shot
- disarm_valid  input  1  single-cycle disarm command
- disarm_ch  input  CH_W  channel to disarm
- ack_valid  input  1  pending-clear strobe
- ack_mask  input  NUM_CH  pending bits to clear
- armed  output  NUM_CH  per-channel armed flags
- pending  output  NUM_CH  per-channel expired-and-unacknowledged flags
- irq  output  1  registered OR of pending
- fire_valid  output  1  one-cycle pulse when a channel expires
- fire_ch  output  CH_W  channel that expired; valid only with fire_valid

## Operation
- Per-channel state: deadline[31:0], period[31:0], armed.
- Scan pointer ptr advances 0..NUM_CH-1 every cycle, wraps to 0, and never stalls.
- Arm:
  - deadline[ch] <= micros + eff_delay (mod 2^32)
  - period[ch] <= arm_period
  - armed[ch] <= 1
  - pending[ch] is left unchanged.
  - eff_delay is arm_delay, clamped to 32'h7FFF_FFFF when arm_delay[31] is 1. The same clamp applies to arm_period.
- Disarm: armed[ch] <= 0. Pending is not touched.
- Expiry test for channel ptr: armed[ptr] and bit 31 of (micros − deadline[ptr]) equals 0. This comparison is wrap-safe.
- On hit:
  - pending[ptr] <= 1
  - fire_valid <= 1, fire_ch <= ptr
  - If period is non-zero: deadline <= deadline + period, and the channel stays armed.
  - If period is zero: armed <= 0.
- Periodic reload adds to the old deadline, not to micros, so there is no drift. If the channel is late by more than one period, successive scans fire back-to-back until it catches up.
- Ack: pending &= ~ack_mask.
- Simultaneous-event priorities:
  - Arm and a scan hit on the same channel: arm wins, no fire, new deadline is taken.
  - Arm and disarm on the same channel: arm wins.
  - Disarm and a scan hit on the same channel: disarm wins, no fire.
  - Ack and fire on the same bit: fire wins, pending stays 1.
- Commands on different channels in the same cycle are all applied.
- arm_ch or disarm_ch ≥ NUM_CH: the command is ignored.

## Timing
- Reset values:
  - armed = 0, pending = 0, irq = 0
  - fire_valid = 0, fire_ch = 0
  - ptr = 0
  - all deadline and period registers = 0
- Arm or disarm takes effect at the next clk edge. The channel is first testable in the following cycle.
- Detection latency after micros reaches the deadline: 1 to NUM_CH cycles.
- One micros tick is 100 cycles. With NUM_CH ≤ 64, every channel is scanned at least once per tick, so expiry is never deferred by more than 1 µs.
- delay 0: fires on that channel's first scan after arming.
- fire_valid asserts in the cycle after the scan hit and lasts exactly 1 cycle.
- pending rises in the same cycle as fire_valid; irq follows 1 cycle later.
- Ack clears pending at the next edge; irq drops 1 cycle after that, provided no other bit is set.
- Reset assertion mid-operation clears all state immediately, asynchronously. Operation resumes on the first clk edge after reset deasserts, with ptr = 0.

## Test plan
- One-shot arm:
  - Stimulus: micros = 1000, arm ch1 with delay 5, period 0.
  - Response: no fire while micros < 1005. At micros = 1005, one fire_valid pulse with fire_ch = 1. Then pending = 4'b0010, irq = 1, armed[1] = 0.
  - Ack with mask 4'b0010: pending = 0, irq = 0.
- Wrap-around:
  - Stimulus: micros = 32'hFFFF_FFFE, arm ch0 with delay 4.
  - Response: fires when micros = 2, and not before or at the counter wrap.
- Periodic:
  - Stimulus: arm ch2 at micros = 0 with delay 10, period 10.
  - Response: fires at micros 10, 20 and 30. Deadline register reads 40 after the third fire, and armed[2] stays 1.
  - Disarm, then run 50 µs: no further fires.
- Collisions:
  - Stimulus: arm ch3 in the exact cycle its expired deadline is scanned.
  - Response: no fire, new deadline used.
  - Stimulus: ack bit 0 in the same cycle ch0 fires.
  - Response: pending[0] stays 1.
- Concurrent expiry:
  - Stimulus: all 4 channels armed with delay 3 at the same micros value.
  - Response: 4 fire pulses carrying distinct fire_ch values within 4 cycles of expiry, and pending = 4'b1111.
- Reset:
  - Stimulus: assert reset low mid-operation with channels armed and pending.
  - Response: all outputs are 0 immediately. No fire occurs after release until a new arm command.
